// File: rtl/ram4002_pkg.sv
// Shared definitions for the 4002 RAM slice: bus phases, I/O opcodes and
// backdoor word-index regions.
package ram4002_pkg;

  typedef enum logic [2:0] {
    A1, A2, A3, M1, M2, X1, X2, X3
  } bus_phase_e;

  localparam logic [3:0] OP_WRM = 4'h0;
  localparam logic [3:0] OP_WMP = 4'h1;
  localparam logic [3:0] OP_WR0 = 4'h4;
  localparam logic [3:0] OP_SBM = 4'h8;
  localparam logic [3:0] OP_RDM = 4'h9;
  localparam logic [3:0] OP_ADM = 4'hB;
  localparam logic [3:0] OP_RD0 = 4'hC;

  localparam logic [6:0] BD_STATUS_BASE = 7'd64;
  localparam logic [6:0] BD_LIMIT       = 7'd80;

  // Ops that put a stored nibble onto the CPU bus at X2.
  function automatic logic op_is_read(input logic [3:0] op);
    return (op == OP_SBM) || (op == OP_RDM) || (op == OP_ADM) || (op[3:2] == OP_RD0[3:2]);
  endfunction

endpackage

// File: rtl/bus_phase_counter.sv
// Tracks the 8-phase 4004 instruction cycle from sync; idle until the first sync.
module bus_phase_counter
  import ram4002_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       sync,
  output bus_phase_e phase,
  output logic       active
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      phase  <= A1;
      active <= 1'b0;
    end else if (sync) begin
      phase  <= A1;
      active <= 1'b1;
    end else if (active) begin
      phase  <= bus_phase_e'(3'(phase) + 3'd1);
    end
  end

endmodule

// File: rtl/ram_4002_wb.sv
// 4002-style RAM/output-port chip with a Wishbone backdoor to every nibble.
// Define RAM_SPLIT_BUS_EN for a split data_i/data_o/data_en bus instead of inout.
module ram_4002_wb
  import ram4002_pkg::*;
#(
  parameter int unsigned CHIP_ID = 0
) (
  input  logic        clock,
  input  logic        reset,
`ifdef RAM_SPLIT_BUS_EN
  input  logic [3:0]  data_i,
  output logic [3:0]  data_o,
  output logic        data_en,
`else
  inout  wire  [3:0]  data,
`endif
  input  logic        sync,
  input  logic        cmd_n,
  input  logic        p0,
  output logic [3:0]  out,
  input  logic [31:0] wb_data_i,
  input  logic [31:0] wb_addr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_strobe_i,
  input  logic        wb_we_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o
);

  bus_phase_e phase;
  logic       active;

  logic [3:0] mem    [4][16];
  logic [3:0] status [4][4];
  logic       selected, src_pending, io_pending;
  logic [1:0] reg_ptr;
  logic [3:0] char_ptr, opcode;

  logic [3:0] bus_in, rd_nib, drive_data, bd_rd;
  logic       drive_en, at_x2, io_exec, wb_req;
  logic [6:0] wb_idx;
  logic       unused_wb_bits;

  bus_phase_counter u_phase (
    .clock  (clock),
    .reset  (reset),
    .sync   (sync),
    .phase  (phase),
    .active (active)
  );

  assign at_x2   = active && (phase == X2);
  assign io_exec = at_x2 && io_pending && selected && cmd_n;
  assign rd_nib  = (opcode[3:2] == OP_RD0[3:2]) ? status[reg_ptr][opcode[1:0]]
                                                : mem[reg_ptr][char_ptr];
  assign drive_en   = io_exec && op_is_read(opcode);
  assign drive_data = drive_en ? rd_nib : '0;

`ifdef RAM_SPLIT_BUS_EN
  assign bus_in  = data_i;
  assign data_o  = drive_data;
  assign data_en = drive_en;
`else
  assign bus_in = data;
  assign data   = drive_en ? drive_data : 4'bz;
`endif

  assign wb_idx         = wb_addr_i[8:2];
  assign wb_req         = wb_cyc_i && wb_strobe_i && !wb_ack_o;
  assign unused_wb_bits = ^{wb_data_i[31:4], wb_addr_i[31:9], wb_addr_i[1:0]};

  // Status words 64..79 share the low four index bits with idx-64.
  always_comb begin
    bd_rd = '0;
    if (wb_idx < BD_STATUS_BASE)
      bd_rd = mem[wb_idx[5:4]][wb_idx[3:0]];
    else if (wb_idx < BD_LIMIT)
      bd_rd = status[wb_idx[3:2]][wb_idx[1:0]];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < 4; r++) begin
        for (int unsigned c = 0; c < 16; c++) mem[r[1:0]][c[3:0]] <= '0;
        for (int unsigned s = 0; s < 4; s++) status[r[1:0]][s[1:0]] <= '0;
      end
      out         <= '0;
      selected    <= 1'b0;
      reg_ptr     <= '0;
      char_ptr    <= '0;
      opcode      <= '0;
      src_pending <= 1'b0;
      io_pending  <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_data_o   <= '0;
    end else begin
      if (wb_req && wb_we_i) begin
        if (wb_idx < BD_STATUS_BASE)
          mem[wb_idx[5:4]][wb_idx[3:0]] <= wb_data_i[3:0];
        else if (wb_idx < BD_LIMIT)
          status[wb_idx[3:2]][wb_idx[1:0]] <= wb_data_i[3:0];
      end
      // Frontdoor writes follow the backdoor so they win a same-nibble collision.
      if (io_exec && opcode == OP_WRM)
        mem[reg_ptr][char_ptr] <= bus_in;
      if (io_exec && opcode[3:2] == OP_WR0[3:2])
        status[reg_ptr][opcode[1:0]] <= bus_in;
      if (io_exec && opcode == OP_WMP)
        out <= bus_in;

      if (at_x2 && !cmd_n) begin
        selected    <= (bus_in[3] == CHIP_ID[0]) && (bus_in[2] == p0);
        reg_ptr     <= bus_in[1:0];
        src_pending <= 1'b1;
      end
      if (active && phase == X3) begin
        if (src_pending) char_ptr <= bus_in;
        src_pending <= 1'b0;
        io_pending  <= 1'b0;
      end
      if (active && phase == M2 && !cmd_n) begin
        opcode     <= bus_in;
        io_pending <= 1'b1;
      end

      wb_ack_o  <= wb_req;
      wb_data_o <= wb_req ? {28'h0, bd_rd} : '0;
    end
  end

endmodule

// File: tb/tb_ram_4002_wb.sv
// Self-checking bench for ram_4002_wb: backdoor vector table, scoreboarded
// Wishbone reads, and hand-built bus cycles for SRC/I/O corner cases.
module tb_ram_4002_wb;
  import ram4002_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        sync = 1'b0, cmd_n = 1'b1, p0 = 1'b1;
  logic [3:0]  tb_drv = '0;
  logic        tb_en = 1'b0;
  wire  [3:0]  data;
  logic [3:0]  out;
  logic [31:0] wb_data_i = '0, wb_addr_i = '0, wb_data_o;
  logic        wb_cyc_i = 1'b0, wb_strobe_i = 1'b0, wb_we_i = 1'b0, wb_ack_o;

  int          checks = 0, failures = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic [6:0]  word;
    logic [3:0]  wd;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[7];

  assign data = tb_en ? tb_drv : 4'bz;

  ram_4002_wb #(.CHIP_ID(0)) dut (
    .clock       (clock),
    .reset       (reset),
    .data        (data),
    .sync        (sync),
    .cmd_n       (cmd_n),
    .p0          (p0),
    .out         (out),
    .wb_data_i   (wb_data_i),
    .wb_addr_i   (wb_addr_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_strobe_i (wb_strobe_i),
    .wb_we_i     (wb_we_i),
    .wb_data_o   (wb_data_o),
    .wb_ack_o    (wb_ack_o)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wb_access(input logic we, input logic [6:0] word, input logic [3:0] wd,
                           input logic [31:0] exp);
    int unsigned lat;
    logic [31:0] e;
    lat = 0;
    @(negedge clock);
    sync = 1'b0; tb_en = 1'b0; cmd_n = 1'b1;
    wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = we;
    wb_addr_i = {23'h0, word, 2'b00}; wb_data_i = {28'h0, wd};
    if (!we) sb_q.push_back(exp);
    do begin
      @(negedge clock);
      lat++;
    end while (!wb_ack_o && lat < 8);
    check($sformatf("wb_ack_latency[%0d]", word), lat, 1);
    if (!we) begin
      e = sb_q.pop_front();
      if (wb_ack_o) check($sformatf("wb_rdata[%0d]", word), wb_data_o, e);
    end
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
    @(negedge clock);
    check($sformatf("wb_ack_single[%0d]", word), wb_ack_o, 0);
  endtask

  // One sync-aligned instruction cycle; a = X2/M2 nibble, b = X3/X2 nibble.
  task automatic bus_cycle(input logic is_src, input logic [3:0] a, input logic [3:0] b,
                           input logic drv_x2, input logic exp_en, input logic [3:0] exp_d,
                           input logic col, input logic [6:0] col_word, input logic [3:0] col_d);
    @(negedge clock);
    sync = 1'b1; cmd_n = 1'b1; tb_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      sync = (i == 7); cmd_n = 1'b1; tb_en = 1'b0;
      if (is_src) begin
        if (i == 6) begin cmd_n = 1'b0; tb_en = 1'b1; tb_drv = a; end
        if (i == 7) begin tb_en = 1'b1; tb_drv = b; end
      end else begin
        if (i == 4) begin cmd_n = 1'b0; tb_en = 1'b1; tb_drv = a; end
        if (i == 6 && drv_x2) begin tb_en = 1'b1; tb_drv = b; end
      end
      if (col && i == 6) begin
        wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = 1'b1;
        wb_addr_i = {23'h0, col_word, 2'b00}; wb_data_i = {28'h0, col_d};
      end
      if (col && i == 7) begin
        check("col_ack", wb_ack_o, 1);
        wb_cyc_i = 1'b0; wb_strobe_i = 1'b0; wb_we_i = 1'b0;
      end
      #1;
      check($sformatf("bus_en_ph%0d_op%0h", i, a), dut.drive_en, (exp_en && i == 6));
      if (exp_en && i == 6) check($sformatf("bus_data_op%0h", a), data, exp_d);
    end
  endtask

  initial begin
    vecs[0] = '{7'd0,   4'h9, 32'h9};
    vecs[1] = '{7'd63,  4'h1, 32'h1};
    vecs[2] = '{7'd64,  4'hE, 32'hE};
    vecs[3] = '{7'd79,  4'h4, 32'h4};
    vecs[4] = '{7'd80,  4'hB, 32'h0};
    vecs[5] = '{7'd100, 4'h5, 32'h0};
    vecs[6] = '{7'd127, 4'h7, 32'h0};

    repeat (2) @(negedge clock);
    check("rst_out", out, 0);
    check("rst_ack", wb_ack_o, 0);
    check("rst_wbdata", wb_data_o, 0);
    check("rst_drive", dut.drive_en, 0);
    reset = 1'b1;

    foreach (vecs[k]) begin
      wb_access(1'b1, vecs[k].word, vecs[k].wd, 32'h0);
      wb_access(1'b0, vecs[k].word, 4'h0, vecs[k].exp);
    end

    // SRC selects reg 1 char 9, WRM 0xA, then backdoor and RDM see it.
    p0 = 1'b1;
    bus_cycle(1'b1, 4'h5, 4'h9, 1'b0, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    bus_cycle(1'b0, OP_WRM, 4'hA, 1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    wb_access(1'b0, 7'd25, 4'h0, 32'hA);
    bus_cycle(1'b0, OP_RDM, 4'h0, 1'b0, 1'b1, 4'hA, 1'b0, 7'd0, 4'h0);

    // p0 mismatch deselects: no write, no drive.
    p0 = 1'b0;
    bus_cycle(1'b1, 4'h5, 4'h3, 1'b0, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    bus_cycle(1'b0, OP_WRM, 4'h5, 1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    wb_access(1'b0, 7'd19, 4'h0, 32'h0);
    bus_cycle(1'b0, OP_RDM, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    p0 = 1'b1;

    // Backdoor status write, then RD2 drives it at X2 only.
    wb_access(1'b1, 7'd66, 4'h7, 32'h0);
    bus_cycle(1'b1, 4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    bus_cycle(1'b0, 4'hE, 4'h0, 1'b0, 1'b1, 4'h7, 1'b0, 7'd0, 4'h0);

    // WR1 lands in status reg 0 char 1 (word 65); word 64 untouched.
    bus_cycle(1'b0, 4'h5, 4'h6, 1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    wb_access(1'b0, 7'd65, 4'h0, 32'h6);
    wb_access(1'b0, 7'd64, 4'h0, 32'hE);

    // ROM-side opcode 2 while selected: nothing changes, no drive.
    bus_cycle(1'b0, 4'h2, 4'hF, 1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    wb_access(1'b0, 7'd0, 4'h0, 32'h9);
    wb_access(1'b0, 7'd100, 4'h0, 32'h0);

    // Same-clock frontdoor WRM 0x3 vs backdoor write 0xF to word 0.
    bus_cycle(1'b0, OP_WRM, 4'h3, 1'b1, 1'b0, 4'h0, 1'b1, 7'd0, 4'hF);
    @(negedge clock);
    sync = 1'b0; tb_en = 1'b0;
    check("col_ack_once", wb_ack_o, 0);
    wb_access(1'b0, 7'd0, 4'h0, 32'h3);

    // WMP, then async reset mid-cycle with a Wishbone read in flight.
    bus_cycle(1'b0, OP_WMP, 4'hC, 1'b1, 1'b0, 4'h0, 1'b0, 7'd0, 4'h0);
    @(negedge clock);
    sync = 1'b0; tb_en = 1'b0;
    check("out_wmp", out, 4'hC);
    wb_cyc_i = 1'b1; wb_strobe_i = 1'b1; wb_we_i = 1'b0; wb_addr_i = {23'h0, 7'd25, 2'b00};
    #2 reset = 1'b0;
    #1 check("out_async_reset", out, 0);
    @(posedge clock);
    #1 check("ack_aborted", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_strobe_i = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    wb_access(1'b0, 7'd25, 4'h0, 32'h0);
    wb_access(1'b0, 7'd66, 4'h0, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_4002_wb.md
Name: ram_4002_wb

Overview:
- 4002-style 4-bit RAM/output-port chip on the 4004-style multiplexed nibble bus.
- Stores 4 registers x 16 main characters (64 nibbles), plus 4 registers x 4 status characters (16 nibbles).
- Drives a 4-bit output port.
- Exposes a Wishbone slave "backdoor" so a host can read and write every nibble. One instance per RAM chip in the system wrapper.

Parameters:
- CHIP_ID, 0, chip-number bit 3 matched during SRC; combines with pin p0 (bit 2) to select 1 of 4 chips on a cmd_n line.

Ports:
- clock, input, 1: single system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- data, inout, 4: multiplexed CPU bus (tristate form).
- sync, input, 1: high for one clock during X3; next clock is A1.
- cmd_n, input, 1: active-low CM-RAM line for this chip's bank.
- p0, input, 1: strap pin, chip-number bit 2.
- out, output, 4: output port.
- wb_data_i, input, 32: backdoor write data; bits [3:0] used.
- wb_addr_i, input, 32: byte address; word index = wb_addr_i[8:2].
- wb_cyc_i, input, 1: Wishbone cycle.
- wb_strobe_i, input, 1: Wishbone strobe, already chip-decoded by the wrapper.
- wb_we_i, input, 1: Wishbone write enable.
- wb_data_o, output, 32: read data, zero-extended nibble.
- wb_ack_o, output, 1: Wishbone acknowledge.

Behaviour:
- Phase counter:
  - 8 phases in order: A1, A2, A3, M1, M2, X1, X2, X3.
  - sync high forces the next phase to A1; otherwise the counter increments, wrapping X3 -> A1.
  - After reset the counter is idle; it does nothing until the first sync.
- Reset values: all memory and status = 0, out = 0, selected = 0, reg/char pointers = 0, pending flags = 0, bus not driven, wb_ack_o = 0, wb_data_o = 0.
- SRC handling:
  - At X2 with cmd_n = 0: selected <= (data[3] == CHIP_ID) && (data[2] == p0); reg_ptr <= data[1:0]; set src_pending.
  - At X3 with src_pending: char_ptr <= data; clear src_pending.
  - A non-matching SRC deselects the chip. Selection persists until the next SRC seen on this cmd_n.
- I/O handling:
  - At M2 with cmd_n = 0: latch opcode <= data; set io_pending.
  - At X2 with io_pending && selected, execute the opcode; clear io_pending at X3.
  - An SRC at X2 and an I/O op are never in the same cycle; SRC takes precedence if both flags are set.
- Opcode actions at X2:
  - 0 WRM: mem[reg][char] <= data.
  - 1 WMP: out <= data.
  - 4-7 WR0-WR3: status[reg][op-4] <= data.
  - 8 SBM, 9 RDM, B ADM: drive mem[reg][char].
  - C-F RD0-RD3: drive status[reg][op-C].
  - 2, 3, A: no action, no drive (ROM/program-memory ops).
- Bus drive: only during X2 of a selected read op; released in every other phase.
- Backdoor addressing: word 0-63 = mem[idx[5:4]][idx[3:0]]; 64-79 = status[(idx-64)[3:2]][(idx-64)[1:0]]; 80-127 reads 0, writes ignored.
- Backdoor handshake:
  - wb_cyc_i && wb_strobe_i && !wb_ack_o produces a registered wb_ack_o one clock later, lasting exactly 1 clock.
  - wb_data_o is valid with the ack.
  - A write commits on the ack clock.
- Collision: a frontdoor write (WRM/WRx) and a backdoor write to the same nibble on the same clock -> the frontdoor write wins; the backdoor write is still acked.
- Reset asserted mid-cycle aborts everything, including an in-flight Wishbone transfer (no ack).

Optional Feature:
- RAM_SPLIT_BUS_EN defined: replace inout data with data_i (in, 4), data_o (out, 4), data_en (out, 1). data_en = 1 exactly when the tristate variant would drive; data_o = 0 when not enabled.
- RAM_SPLIT_BUS_EN undefined: single inout data, driven with data_o when enabled and high-Z otherwise.

Decomposition:
- Shared package ram4002_pkg: bus-phase enum (A1..X3), I/O opcode constants (WRM, WMP, WR0, SBM, RDM, ADM, RD0), backdoor region bounds (64, 80).
- One sub-module: bus_phase_counter (sync -> phase), reusable by the cpu and rom blocks.

Test Plan:
- SRC with data 0x5 at X2 / 0x9 at X3, CHIP_ID = 0, p0 = 1 -> selected, reg 1, char 9. Then WRM with 0xA -> backdoor read of word 25 returns 0x0000000A, ack 1 clock after strobe.
- Same SRC with p0 = 0 -> not selected; WRM leaves memory at 0 and the bus is never driven.
- Backdoor write 0x7 to word 66, SRC reg 0, RD2 -> chip drives 0x7 at X2 only (data_en 1 for exactly that clock).
- WMP with 0xC -> out = 0xC; assert reset low asynchronously -> out = 0 immediately, memory reads 0.
- Opcode 0x2 (WRR) while selected -> no memory change, no bus drive; backdoor read of word 100 -> 0.
- Frontdoor WRM 0x3 and backdoor write 0xF to the same nibble on the same clock -> reads 0x3, wb_ack_o pulses once.
